// File: rtl/direct_sound_fifo.sv
// direct_sound_fifo: 8x32-bit sample FIFO that plays bytes on each timer tick and requests 4-word DMA refills.
module direct_sound_fifo (
    input  logic        clock_16,
    input  logic        reset,
    input  logic        fifo_wr_en,
    input  logic [31:0] fifo_wr_data,
    input  logic        fifo_clear,
    input  logic        timer_tick,
    output logic [7:0]  sample_out,
    output logic        sample_valid,
    output logic        dma_req,
    output logic [5:0]  fifo_count,
    output logic        overflow_err,
    output logic        underflow_err
);
    typedef enum logic {ARMED, PENDING} state_t;
    state_t      state;
    logic [31:0] mem [8];
    logic [2:0]  wr_ptr;
    logic [2:0]  words_due;
    logic [4:0]  rd_ptr;
    logic        wr_ok;
    logic        rd_ok;
    logic [5:0]  count_nxt;
    logic [31:0] rd_word;
    assign wr_ok     = fifo_wr_en && fifo_count <= 6'd28;
    assign rd_ok     = timer_tick && fifo_count != 6'd0;
    assign count_nxt = fifo_count + (wr_ok ? 6'd4 : 6'd0) - (rd_ok ? 6'd1 : 6'd0);
    assign rd_word   = mem[rd_ptr[4:2]];
    always_ff @(posedge clock_16)
        if (!reset && !fifo_clear && wr_ok) mem[wr_ptr] <= fifo_wr_data;
    always_ff @(posedge clock_16) begin
        if (reset || fifo_clear) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            dma_req       <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            words_due     <= '0;
            state         <= ARMED;
        end else begin
            sample_valid <= rd_ok;
            dma_req      <= 1'b0;
            fifo_count   <= count_nxt;
            if (wr_ok) wr_ptr <= wr_ptr + 3'd1;
            if (rd_ok) begin
                sample_out <= rd_word[{rd_ptr[1:0], 3'b000} +: 8];
                rd_ptr     <= rd_ptr + 5'd1;
            end
            if (fifo_wr_en && !wr_ok) overflow_err <= 1'b1;
            if (timer_tick && !rd_ok) underflow_err <= 1'b1;
            // Refill is requested on the look-ahead count so the pulse aligns with the drop to 16.
            if (state == ARMED) begin
                if (count_nxt <= 6'd16) begin
                    dma_req   <= 1'b1;
                    words_due <= 3'd4;
                    state     <= PENDING;
                end
            end else if (wr_ok) begin
                words_due <= words_due - 3'd1;
                if (words_due == 3'd1) state <= ARMED;
            end
        end
    end
endmodule

// File: tb/tb_direct_sound_fifo.sv
// tb_direct_sound_fifo: random and directed stimulus against a queue-of-bytes reference model with a sample scoreboard.
module tb_direct_sound_fifo;
    logic        clock_16 = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_wr_en = 1'b0;
    logic [31:0] fifo_wr_data = '0;
    logic        fifo_clear = 1'b0;
    logic        timer_tick = 1'b0;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        dma_req;
    logic [5:0]  fifo_count;
    logic        overflow_err;
    logic        underflow_err;
    int checks = 0;
    int passes = 0;
    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_last;
    logic       m_ovf, m_unf, m_armed, m_dma, m_valid;
    int         m_due;
    direct_sound_fifo dut (
        .clock_16(clock_16), .reset(reset), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_clear(fifo_clear), .timer_tick(timer_tick), .sample_out(sample_out),
        .sample_valid(sample_valid), .dma_req(dma_req), .fifo_count(fifo_count),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );
    always #5 clock_16 = ~clock_16;
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask
    // Scoreboard monitor: every sample_valid must match the next expected popped byte.
    always @(negedge clock_16)
        if (sample_valid) begin
            if (exp_q.size() == 0) check("unexpected_sample_valid", 1, 0);
            else check("sample_data", int'(sample_out), int'(exp_q.pop_front()));
        end
    task automatic model(input logic r, input logic w, input logic c, input logic t, input logic [31:0] d);
        int  cnt;
        logic was_armed;
        if (r || c) begin
            q = {}; m_last = 8'h00; m_ovf = 0; m_unf = 0; m_armed = 1; m_due = 0; m_dma = 0; m_valid = 0;
            return;
        end
        cnt = q.size();
        was_armed = m_armed;
        m_dma = 0;
        m_valid = 0;
        if (t) begin
            if (cnt > 0) begin
                m_last = q.pop_front();
                exp_q.push_back(m_last);
                m_valid = 1;
            end else m_unf = 1;
        end
        if (w) begin
            if (cnt <= 28) begin
                for (int i = 0; i < 4; i++) q.push_back(d[8*i +: 8]);
                if (!was_armed) begin
                    m_due--;
                    if (m_due == 0) m_armed = 1;
                end
            end else m_ovf = 1;
        end
        if (was_armed && q.size() <= 16) begin
            m_dma = 1; m_due = 4; m_armed = 0;
        end
    endtask
    task automatic step(input logic r, input logic w, input logic c, input logic t, input logic [31:0] d);
        reset = r; fifo_wr_en = w; fifo_clear = c; timer_tick = t; fifo_wr_data = d;
        @(posedge clock_16);
        model(r, w, c, t, d);
        #1;
        check("fifo_count", int'(fifo_count), q.size());
        check("dma_req", int'(dma_req), int'(m_dma));
        check("sample_valid", int'(sample_valid), int'(m_valid));
        check("sample_out", int'(sample_out), int'(m_last));
        check("overflow_err", int'(overflow_err), int'(m_ovf));
        check("underflow_err", int'(underflow_err), int'(m_unf));
        reset = 0; fifo_wr_en = 0; fifo_clear = 0; timer_tick = 0;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0);
    endtask
    initial begin
        step(1, 1, 0, 1, 32'hdeadbeef);
        step(1, 0, 0, 0, 32'h0);
        idle(3);
        check("pending_no_repulse", int'(dma_req), 0);
        step(0, 1, 0, 0, 32'h04030201);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 32'h0);
            check("byte_order", int'(sample_out), i + 1);
            idle(2);
        end
        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 32'h10203040 + 32'h04040404 * i);
        check("full_count", int'(fifo_count), 32);
        check("overflow_set", int'(overflow_err), 1);
        for (int i = 0; i < 32; i++) step(0, 0, 0, 1, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, $urandom);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0);
        idle(2);
        step(0, 0, 0, 1, 32'h0);
        check("refill_pulse_at_16", int'(dma_req), 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, $urandom);
        idle(3);
        check("refill_full_count", int'(fifo_count), 32);
        step(1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'haabbccdd);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0);
        step(0, 1, 0, 1, 32'h11223344);
        check("pop_old_byte", int'(sample_out), 8'haa);
        check("count_after_mixed", int'(fifo_count), 4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 1, 32'h0);
        check("underflow_set", int'(underflow_err), 1);
        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, $urandom);
        step(0, 1, 0, 1, 32'h55667788);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0);
        step(0, 1, 1, 1, 32'h99999999);
        check("clear_count", int'(fifo_count), 0);
        check("clear_valid", int'(sample_valid), 0);
        for (int i = 0; i < 3000; i++) begin
            int w_pct, t_pct;
            w_pct = (i / 500) % 2 ? 60 : 25;
            t_pct = (i / 500) % 2 ? 30 : 55;
            step($urandom_range(0, 499) == 0, $urandom_range(0, 99) < w_pct,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 99) < t_pct, $urandom);
        end
        idle(2);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
